axis_i2c_slave: RTL

- I2C target (slave) matching the team's AXI-Stream I2C master (axis_i2c_top); responds at a fixed 7-bit address.
- Write transfers: received bytes go out on an AXI-Stream master port.
- Read transfers: bytes from an AXI-Stream slave port are shifted out on SDA.
- SCL and SDA are oversampled on the system clock. No clock stretching.

---
 rtl/axis_i2c_slave.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/axis_i2c_slave.sv
// axis_i2c_slave: I2C target at a fixed 7-bit address bridging to AXI-Stream.
// Write bytes leave on m_axis_*, read bytes are taken from s_axis_*.
// Optional build macro I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority
// filter on SCL and SDA after the synchronizer.
module axis_i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
    input  logic       clk_i,
    input  logic       arstn_i,
    input  logic       i2c_scl_i,
    inout  wire        i2c_sda_io,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic       busy_o,
    output logic       stop_o
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_WR_DATA  = 3'd3;
    localparam logic [2:0] ST_WR_ACK   = 3'd4;
    localparam logic [2:0] ST_RD_DATA  = 3'd5;
    localparam logic [2:0] ST_RD_ACK   = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_w, sda_w;
    logic       scl_prev_q, sda_prev_q;

    // Two-flop synchronizers; reset to the idle bus level to avoid false edges.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], i2c_scl_i};
            sda_sync_q <= {sda_sync_q[0], i2c_sda_io};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, sda_hist_q;
    logic       scl_flt_q, sda_flt_q;

    // Majority of three consecutive samples suppresses single-cycle pulses.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_flt_q  <= 1'b1;
            sda_flt_q  <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
            scl_flt_q  <= (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1]) |
                          (scl_hist_q[0] & scl_hist_q[1]);
            sda_flt_q  <= (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1]) |
                          (sda_hist_q[0] & sda_hist_q[1]);
        end
    end

    assign scl_w = scl_flt_q;
    assign sda_w = sda_flt_q;
`else
    assign scl_w = scl_sync_q[1];
    assign sda_w = sda_sync_q[1];
`endif

    // Previous sampled levels for edge detection.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_w;
            sda_prev_q <= sda_w;
        end
    end

    // SCL edges only count when SDA is steady in the same cycle.
    logic sda_steady, scl_rise, scl_fall, start_det, stop_det;
    assign sda_steady = (sda_w == sda_prev_q);
    assign scl_rise   = scl_w & ~scl_prev_q & sda_steady;
    assign scl_fall   = ~scl_w & scl_prev_q & sda_steady;
    assign start_det  = scl_w & scl_prev_q & sda_prev_q & ~sda_w;
    assign stop_det   = scl_w & scl_prev_q & ~sda_prev_q & sda_w;

    logic [2:0] state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [6:0] tx_q, tx_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] m_tdata_q, m_tdata_d;
    logic       m_tvalid_q, m_tvalid_d;
    logic       s_tready_q, s_tready_d;
    logic       busy_q, busy_d;
    logic       stop_q, stop_d;
    logic       rw_q, rw_d;
    logic       hs_done_q, hs_done_d;

    logic [7:0] rx_byte, tx_byte;
    logic       hs_now;
    assign rx_byte = {shift_q, sda_w};
    assign tx_byte = s_axis_tvalid ? s_axis_tdata : FILL_BYTE;
    assign hs_now  = m_tvalid_q & m_axis_tready;

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 7'd0;
            tx_q       <= 7'd0;
            sda_oe_q   <= 1'b0;
            m_tdata_q  <= 8'd0;
            m_tvalid_q <= 1'b0;
            s_tready_q <= 1'b0;
            busy_q     <= 1'b0;
            stop_q     <= 1'b0;
            rw_q       <= 1'b0;
            hs_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            sda_oe_q   <= sda_oe_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            s_tready_q <= s_tready_d;
            busy_q     <= busy_d;
            stop_q     <= stop_d;
            rw_q       <= rw_d;
            hs_done_q  <= hs_done_d;
        end
    end

    // Next-state logic; START/STOP override any bit-level activity.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        sda_oe_d   = sda_oe_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        s_tready_d = 1'b0;
        busy_d     = busy_q;
        stop_d     = 1'b0;
        rw_d       = rw_q;
        hs_done_d  = hs_done_q;

        if (hs_now) begin
            m_tvalid_d = 1'b0;
            hs_done_d  = 1'b1;
        end

        if (start_det) begin
            state_d    = ST_ADDR;
            bit_cnt_d  = 4'd0;
            sda_oe_d   = 1'b0;
            m_tvalid_d = 1'b0;
        end else if (stop_det) begin
            state_d    = ST_IDLE;
            sda_oe_d   = 1'b0;
            m_tvalid_d = 1'b0;
            stop_d     = 1'b1;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (shift_q == SLAVE_ADDR) begin
                                busy_d  = 1'b1;
                                rw_d    = sda_w;
                                state_d = ST_ADDR_ACK;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (rw_q) begin
                            tx_d       = tx_byte[6:0];
                            sda_oe_d   = ~tx_byte[7];
                            s_tready_d = s_axis_tvalid;
                            bit_cnt_d  = 4'd1;
                            state_d    = ST_RD_DATA;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = ST_WR_DATA;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            m_tdata_d  = rx_byte;
                            m_tvalid_d = 1'b1;
                            hs_done_d  = 1'b0;
                        end
                    end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
                        if (hs_done_q || hs_now) begin
                            sda_oe_d = 1'b1;
                            state_d  = ST_WR_ACK;
                        end else begin
                            m_tvalid_d = 1'b0;
                            state_d    = ST_IGNORE;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_WR_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RD_ACK;
                        end else begin
                            sda_oe_d  = ~tx_q[6];
                            tx_d      = {tx_q[5:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise && sda_w) begin
                        state_d = ST_IGNORE;
                    end else if (scl_fall) begin
                        tx_d       = tx_byte[6:0];
                        sda_oe_d   = ~tx_byte[7];
                        s_tready_d = s_axis_tvalid;
                        bit_cnt_d  = 4'd1;
                        state_d    = ST_RD_DATA;
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // Open-drain pad; reset releases the line without waiting for a clock.
    assign i2c_sda_io    = (sda_oe_q && arstn_i) ? 1'b0 : 1'bz;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign s_axis_tready = s_tready_q;
    assign busy_o        = busy_q;
    assign stop_o        = stop_q;

endmodule
